// File: rtl/hdbe_pkg.sv
// Shared constants and helpers for the branch-dataflow blocks.
// Branch polarity encoding and pointer-width sizing.
package hdbe_pkg;

    localparam logic BR_TRUE  = 1'b1;
    localparam logic BR_FALSE = 1'b0;

    // Never returns 0 so a depth-1 or depth-2 structure still gets a real vector.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hdbe_sync_fifo.sv
// Synchronous FIFO with occupancy count; power-of-two DEPTH, naturally wrapping pointers.
// Latency: a pushed entry appears at the head one cycle later (no bypass).
// Backpressure: caller must not push when full_o or pop when empty_o.
module hdbe_sync_fifo
    import hdbe_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = clog2_min1(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign full_o    = (cnt_q == CW'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the head is only observed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/br_cond_op.sv
// Conditional-branch stage: queues {cond, tag} tokens and steers each to the true or false successor.
// Latency: one cycle from accepted input to visible output; strict FIFO order, no bypass.
// Backpressure: in_ready drops when full or disabled; a stalled head blocks all later tokens.
module br_cond_op
    import hdbe_pkg::*;
#(
    parameter int ParamTagWidth = 8,
    parameter int ParamDepth    = 2,
    parameter int ParamCntWidth = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic                     in_cond,
    input  logic [ParamTagWidth-1:0] in_tag,
    output logic                     in_ready,
    output logic                     true_valid,
    output logic [ParamTagWidth-1:0] true_tag,
    input  logic                     true_ready,
    output logic                     false_valid,
    output logic [ParamTagWidth-1:0] false_tag,
    input  logic                     false_ready,
    input  logic                     clear_cnt,
    output logic [ParamCntWidth-1:0] taken_cnt,
    output logic [ParamCntWidth-1:0] not_taken_cnt
);

    localparam int W = ParamTagWidth + 1;

    logic                     fifo_full, fifo_empty;
    logic [W-1:0]             head_dat;
    logic                     head_cond;
    logic [ParamTagWidth-1:0] head_tag;
    logic                     head_vis, push, pop_true, pop_false;
    logic [ParamCntWidth-1:0] taken_q, taken_d, not_taken_q, not_taken_d;

    assign head_cond = head_dat[W-1];
    assign head_tag  = head_dat[ParamTagWidth-1:0];

    // Full blocks a push even when the head pops this cycle: no same-cycle refill.
    assign in_ready = enable && !fifo_full;
    assign push     = in_valid && in_ready;

    assign head_vis    = enable && !fifo_empty;
    assign true_valid  = head_vis && (head_cond == BR_TRUE);
    assign false_valid = head_vis && (head_cond == BR_FALSE);
    assign true_tag    = fifo_empty ? '0 : head_tag;
    assign false_tag   = fifo_empty ? '0 : head_tag;

    assign pop_true  = true_valid && true_ready;
    assign pop_false = false_valid && false_ready;

    hdbe_sync_fifo #(
        .WIDTH (W),
        .DEPTH (ParamDepth)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i ({in_cond, in_tag}),
        .pop_i      (pop_true || pop_false),
        .pop_dat_o  (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        taken_d     = taken_q;
        not_taken_d = not_taken_q;
        if (clear_cnt) begin
            taken_d     = '0;
            not_taken_d = '0;
        end else begin
            if (pop_true && (taken_q != '1))         taken_d     = taken_q + ParamCntWidth'(1);
            if (pop_false && (not_taken_q != '1))    not_taken_d = not_taken_q + ParamCntWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q     <= '0;
            not_taken_q <= '0;
        end else begin
            taken_q     <= taken_d;
            not_taken_q <= not_taken_d;
        end
    end

    assign taken_cnt     = taken_q;
    assign not_taken_cnt = not_taken_q;

endmodule

// File: tb/tb_br_cond_op.sv
// Bench for br_cond_op: directed scenarios then random traffic, checked against a queue model.
module tb_br_cond_op;

    localparam int TW    = 8;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable, in_valid, in_cond, in_ready;
    logic [TW-1:0] in_tag;
    logic          true_valid, true_ready, false_valid, false_ready, clear_cnt;
    logic [TW-1:0] true_tag, false_tag;
    logic [CW-1:0] taken_cnt, not_taken_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [TW:0] mq[$];
    int          m_taken, m_nt;

    always #5 clk = ~clk;

    br_cond_op #(
        .ParamTagWidth (TW),
        .ParamDepth    (DEPTH),
        .ParamCntWidth (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_cond       (in_cond),
        .in_tag        (in_tag),
        .in_ready      (in_ready),
        .true_valid    (true_valid),
        .true_tag      (true_tag),
        .true_ready    (true_ready),
        .false_valid   (false_valid),
        .false_tag     (false_tag),
        .false_ready   (false_ready),
        .clear_cnt     (clear_cnt),
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
    );

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic cycle();
        bit          e_rdy, e_tv, e_fv, do_pt, do_pf, do_push;
        logic [TW-1:0] e_tag;
        @(negedge clk);
        e_rdy = enable && (mq.size() < DEPTH);
        e_tv  = enable && (mq.size() > 0) && (mq[0][TW] == 1'b1);
        e_fv  = enable && (mq.size() > 0) && (mq[0][TW] == 1'b0);
        e_tag = (mq.size() > 0) ? mq[0][TW-1:0] : '0;
        chk("in_ready",      {15'd0, in_ready},    {15'd0, e_rdy});
        chk("true_valid",    {15'd0, true_valid},  {15'd0, e_tv});
        chk("false_valid",   {15'd0, false_valid}, {15'd0, e_fv});
        chk("true_tag",      {8'd0, true_tag},     {8'd0, e_tag});
        chk("false_tag",     {8'd0, false_tag},    {8'd0, e_tag});
        chk("taken_cnt",     {12'd0, taken_cnt},     16'(m_taken));
        chk("not_taken_cnt", {12'd0, not_taken_cnt}, 16'(m_nt));
        do_pt   = e_tv && true_ready;
        do_pf   = e_fv && false_ready;
        do_push = in_valid && e_rdy;
        @(posedge clk);
        if (do_pt || do_pf) void'(mq.pop_front());
        if (do_push) mq.push_back({in_cond, in_tag});
        if (clear_cnt) begin
            m_taken = 0;
            m_nt    = 0;
        end else begin
            if (do_pt && m_taken < CMAX) m_taken++;
            if (do_pf && m_nt < CMAX)    m_nt++;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_cond = 1'b0; in_tag = '0;
        true_ready = 1'b0; false_ready = 1'b0; clear_cnt = 1'b0;
        m_taken = 0; m_nt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single true token, delivered the cycle after the push.
        in_valid = 1'b1; in_cond = 1'b1; in_tag = 8'h05; true_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (2) cycle();

        // A stalled true head holds back the false token behind it.
        true_ready = 1'b0; false_ready = 1'b1;
        in_valid = 1'b1; in_cond = 1'b1; in_tag = 8'h0A; cycle();
        in_cond = 1'b0; in_tag = 8'h0B; cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        true_ready = 1'b1;
        repeat (3) cycle();

        // Fill, attempt a push while full, single pop, then refill.
        true_ready = 1'b0; false_ready = 1'b0;
        in_valid = 1'b1; in_cond = 1'b1; in_tag = 8'h21; cycle();
        in_cond = 1'b0; in_tag = 8'h22; cycle();
        in_tag = 8'h23; repeat (2) cycle();
        true_ready = 1'b1; cycle();
        true_ready = 1'b0; cycle();
        in_valid = 1'b0; true_ready = 1'b1; false_ready = 1'b1;
        repeat (4) cycle();

        // Stall with a token queued; it resumes unchanged.
        in_valid = 1'b1; in_cond = 1'b1; in_tag = 8'h44; cycle();
        in_valid = 1'b0; enable = 1'b0; true_ready = 1'b1;
        repeat (3) cycle();
        clear_cnt = 1'b1; cycle();
        clear_cnt = 1'b0; enable = 1'b1;
        repeat (2) cycle();

        // Saturate the not-taken counter, then clear it against a concurrent pop.
        in_valid = 1'b1; in_cond = 1'b0; false_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_tag = 8'(i + 8'h60);
            cycle();
        end
        in_valid = 1'b0; repeat (2) cycle();
        in_valid = 1'b1; in_tag = 8'h77; cycle();
        in_valid = 1'b0; clear_cnt = 1'b1; cycle();
        clear_cnt = 1'b0; repeat (2) cycle();

        // Asynchronous reset with two tokens queued.
        true_ready = 1'b0; false_ready = 1'b0; in_valid = 1'b1;
        in_cond = 1'b1; in_tag = 8'h91; cycle();
        in_cond = 1'b0; in_tag = 8'h92; cycle();
        in_valid = 1'b0; true_ready = 1'b1; false_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_true_valid",  {15'd0, true_valid},  16'd0);
        chk("rst_false_valid", {15'd0, false_valid}, 16'd0);
        chk("rst_true_tag",    {8'd0, true_tag},     16'd0);
        chk("rst_taken_cnt",   {12'd0, taken_cnt},   16'd0);
        mq.delete(); m_taken = 0; m_nt = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) cycle();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            enable      = ($urandom_range(0, 9) != 0);
            in_valid    = 1'($urandom_range(0, 1));
            in_cond     = 1'($urandom_range(0, 1));
            in_tag      = 8'($urandom);
            true_ready  = 1'($urandom_range(0, 1));
            false_ready = 1'($urandom_range(0, 1));
            clear_cnt   = ($urandom_range(0, 24) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
